// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
//   Bundles the controller's request/response and datapath-control signals.
//
//   Handshake: a request is accepted on a rising edge where start=1 and
//   ready=1. The result is offered while result_valid=1 and is held stable
//   until the consumer samples result_ack=1 on a rising edge. start is
//   ignored while ready=0; result_ack is ignored while result_valid=0.
//
//   Modports:
//     slave  - the controller (serial_add_ctrl)
//     master - the requester / datapath environment around it
//
//   Signals:
//     start        request one serial addition
//     ready        controller idle, start will be accepted
//     load         parallel-load strobe to both operand PISO registers
//     shift        shift enable to both operand PISO registers
//     carry_clr    clears the external carry flip-flop
//     sum_bit      full-adder sum bit, LSB first, valid while shift=1
//     cout         full-adder carry out, valid while shift=1
//     bit_idx      index of the bit currently being added
//     result       assembled sum, carry in the MSB
//     result_valid result complete and stable
//     result_ack   consumer has taken result
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             start;
    logic             ready;
    logic             load;
    logic             shift;
    logic             carry_clr;
    logic             sum_bit;
    logic             cout;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic             result_ack;

    modport slave (
        input  start, sum_bit, cout, result_ack,
        output ready, load, shift, carry_clr, bit_idx, result, result_valid
    );

    modport master (
        output start, sum_bit, cout, result_ack,
        input  ready, load, shift, carry_clr, bit_idx, result, result_valid
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Control FSM for a bit-serial adder built from two external PISO operand
//   registers, a full adder and a carry flip-flop. One accepted start runs:
//   one LOAD cycle (load PISOs, clear carry, clear result), WIDTH SHIFT
//   cycles (capture sum_bit LSB first, cout on the last bit), then DONE
//   until result_ack is sampled.
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     bus        serial_add_ctrl_if.slave (handshake + datapath control)
//     dbg_state  current FSM state (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_add_ctrl_if.slave        bus,
    output logic [1:0]              dbg_state
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] bit_idx_q;
    logic [WIDTH:0]   result_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore output decode
    always_comb begin
        state_d          = state_q;
        bus.ready        = 1'b0;
        bus.load         = 1'b0;
        bus.shift        = 1'b0;
        bus.carry_clr    = 1'b0;
        bus.result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.load      = 1'b1;
                bus.carry_clr = 1'b1;
                state_d       = SHIFT;
            end
            SHIFT: begin
                bus.shift = 1'b1;
                if (bit_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.result_valid = 1'b1;
                // A start arriving together with the ack is not taken here;
                // it is seen again once the FSM is back in IDLE.
                if (bus.result_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result assembly and bit counter. result is only touched in LOAD
    // (clear) and SHIFT (bit writes), so it holds its last value in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx_q <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    bit_idx_q <= '0;
                    result_q  <= '0;
                end
                SHIFT: begin
                    result_q[bit_idx_q] <= bus.sum_bit;
                    if (bit_idx_q == LAST_IDX) begin
                        // Counter parks on the last index; no wrap in SHIFT.
                        result_q[WIDTH] <= bus.cout;
                    end else begin
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bit_idx = bit_idx_q;
    assign bus.result  = result_q;
    assign dbg_state   = state_q;
endmodule
